// File: rtl/mdu.sv
// mdu: iterative RV64M multiply/divide unit for the execute stage.
//   Multiply is shift-add and divide is restoring, both one bit per cycle.
//   Divide special cases (divide by zero, signed overflow) and reserved ops
//   skip the iterative states and go straight to DONE.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   valid, op      request present, operation code (0..9, 10..15 reserved)
//   a, b           rs1 / rs2 operands
//   flush          kill the in-flight op, return to IDLE
//   ready          idle and accepting a request
//   done           single-cycle pulse, result on c is valid
//   c              registered result, held until the next DONE
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    output logic        ready,
    output logic        done,
    output logic [63:0] c
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    // x: multiplicand / divisor magnitude
    // y: multiplier / dividend shifting out, quotient shifting in
    // acc: product / partial remainder
    logic [63:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic        wop_q, wop_d, remop_q, remop_d, negq_q, negq_d, negr_q, negr_d;
    logic [63:0] c_q, c_d;
    logic        ready_q, done_q;

    function automatic logic [63:0] wfix(input logic w, input logic [63:0] v);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    logic        is_w, is_sgn, is_rem, is_mul, is_div;
    logic [63:0] ax, bx, amag, bmag;
    logic        a_neg, b_neg, div_zero, div_ovf;
    logic [63:0] mul_acc;
    logic [64:0] div_sh;
    logic        div_ge;
    logic [63:0] div_rem, div_quo, q_fix, r_fix;

    always_comb begin
        is_mul = (op == 4'd0) || (op == 4'd1);
        is_div = (op >= 4'd2) && (op <= 4'd9);
        is_w   = (op == 4'd1) || (op >= 4'd6 && op <= 4'd9);
        is_sgn = (op == 4'd2) || (op == 4'd4) || (op == 4'd6) || (op == 4'd8);
        is_rem = (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);

        // Operands at their working width, extended to 64 bits
        if (is_w && is_sgn) begin
            ax = {{32{a[31]}}, a[31:0]};
            bx = {{32{b[31]}}, b[31:0]};
        end else if (is_w) begin
            ax = {32'b0, a[31:0]};
            bx = {32'b0, b[31:0]};
        end else begin
            ax = a;
            bx = b;
        end
        a_neg    = is_sgn && ax[63];
        b_neg    = is_sgn && bx[63];
        amag     = a_neg ? -ax : ax;
        bmag     = b_neg ? -bx : bx;
        div_zero = (bx == 64'd0);
        div_ovf  = is_sgn && (bx == {64{1'b1}}) &&
                   (ax == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

        mul_acc = acc_q + (y_q[0] ? x_q : 64'd0);
        div_sh  = {acc_q, y_q[63]};
        div_ge  = (div_sh >= {1'b0, x_q});
        div_rem = div_ge ? (div_sh[63:0] - x_q) : div_sh[63:0];
        div_quo = {y_q[62:0], div_ge};
        q_fix   = negq_q ? -div_quo : div_quo;
        r_fix   = negr_q ? -div_rem : div_rem;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        wop_d   = wop_q;
        remop_d = remop_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (valid && !flush) begin
                    wop_d   = is_w;
                    remop_d = is_rem;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    acc_d   = 64'd0;
                    if (is_mul) begin
                        x_d     = ax;
                        y_d     = bx;
                        cnt_d   = is_w ? 7'd32 : 7'd64;
                        state_d = S_MUL;
                    end else if (is_div && div_zero) begin
                        c_d     = wfix(is_w, is_rem ? ax : {64{1'b1}});
                        state_d = S_DONE;
                    end else if (is_div && div_ovf) begin
                        c_d     = wfix(is_w, is_rem ? 64'd0 : ax);
                        state_d = S_DONE;
                    end else if (is_div) begin
                        x_d     = bmag;
                        // W dividends are left-aligned so the top bit shifts out first
                        y_d     = is_w ? {amag[31:0], 32'b0} : amag;
                        cnt_d   = is_w ? 7'd32 : 7'd64;
                        state_d = S_DIV;
                    end else begin
                        c_d     = 64'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    c_d     = wfix(wop_q, mul_acc);
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_rem;
                y_d   = div_quo;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    c_d     = wfix(wop_q, remop_q ? r_fix : q_fix);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 7'd0;
            c_d     = c_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            x_q     <= 64'd0;
            y_q     <= 64'd0;
            acc_q   <= 64'd0;
            wop_q   <= 1'b0;
            remop_q <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            c_q     <= 64'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            wop_q   <= wop_d;
            remop_q <= remop_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            c_q     <= c_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign c     = c_q;
endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset, valid, flush;
    logic [3:0]  op;
    logic [63:0] a, b, c;
    logic        ready, done;

    mdu dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
        .flush(flush), .ready(ready), .done(done), .c(c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] c;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_c"}, c, e.c);
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic issue(input string nm, input logic [3:0] o, input logic [63:0] aa,
                         input logic [63:0] bb, input logic [63:0] exp, input int n,
                         input bit expect_done);
        int t = 0;
        while (!ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got ready=0 expected 1", nm);
        end
        valid = 1'b1;
        op = o;
        a = aa;
        b = bb;
        if (expect_done) sb.push_back('{exp, cyc + n + 1, nm});
        @(negedge clk);
        valid = 1'b0;
        // Scramble inputs: in-flight result must not depend on them
        op = 4'd3;
        a = ~aa;
        b = ~bb;
    endtask

    localparam logic [3:0] MUL = 0, MULW = 1, DIV = 2, DIVU = 3, REM = 4, REMU = 5,
                           DIVW = 6, DIVUW = 7, REMW = 8, REMUW = 9;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k, bad, t;
        logic [63:0] c_before;
        reset = 1'b1; valid = 1'b0; flush = 1'b0; op = 4'd0; a = 64'd0; b = 64'd0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_c", c, 64'd0);
        reset = 1'b0;

        // MUL with ready held low for the whole op
        issue("mul_neg1x3", MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1);
        bad = 0;
        for (int i = 0; i < 65; i++) begin
            if (ready) bad = 1;
            @(negedge clk);
        end
        check("mul_busy_ready_low", 64'(bad), 64'd0);
        check("mul_ready_after", 64'(ready), 64'd1);

        issue("mulw", MULW, 64'hDEAD_0000_0000_FFFF, 64'h0000_0000_0001_0001, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1);
        issue("mulw_wrap", MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 1);
        issue("div_100_7", DIV, 64'd100, 64'd7, 64'd14, 64, 1);
        issue("div_m100_7", DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64, 1);
        issue("rem_m100_7", REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1);
        issue("div_7_m2", DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1);
        issue("rem_7_m2", REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64, 1);
        issue("divu_big", DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64, 1);
        issue("remu_big", REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 64, 1);
        issue("divw_m7_2", DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1);
        issue("remw_m7_2", REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1);
        issue("divuw", DIVUW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 32, 1);
        issue("remuw", REMUW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'd1, 32, 1);
        issue("divu_by0", DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        issue("remu_by0", REMU, 64'd5, 64'd0, 64'd5, 0, 1);
        issue("rem_ovf", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1);
        issue("div_ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1);
        issue("divw_ovf", DIVW, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 1);
        issue("remw_by0", REMW, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 0, 1);
        issue("reserved", 4'd12, 64'd9, 64'd9, 64'd0, 0, 1);

        // Flush wins over valid in IDLE
        t = 0;
        while (!ready && t < 300) begin @(negedge clk); t++; end
        valid = 1'b1; flush = 1'b1; op = MUL; a = 64'd3; b = 64'd3;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        check("flush_wins_ready", 64'(ready), 64'd1);

        // Flush mid-divide, then a new MUL right away
        c_before = c;
        issue("div_killed", DIV, 64'd100, 64'd7, 64'd0, 64, 0);
        k = cyc - 1;
        while (cyc < k + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(ready), 64'd1);
        check("flush_c_kept", c, c_before);
        issue("mul_after_flush", MUL, 64'd6, 64'd7, 64'd42, 64, 1);

        // Reset mid-divide
        issue("divu_reset", DIVU, 64'd1000, 64'd3, 64'd0, 64, 0);
        k = cyc - 1;
        while (cyc < k + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_ready", 64'(ready), 64'd1);
        check("rst_mid_c", c, 64'd0);

        // Request held valid through DONE is re-accepted in the following IDLE cycle
        valid = 1'b1; op = DIVU; a = 64'd5; b = 64'd0;
        sb.push_back('{64'hFFFF_FFFF_FFFF_FFFF, cyc + 1, "held_1"});
        @(negedge clk);
        check("held_busy_ready", 64'(ready), 64'd0);
        @(negedge clk);
        check("held_idle_ready", 64'(ready), 64'd1);
        sb.push_back('{64'hFFFF_FFFF_FFFF_FFFF, cyc + 1, "held_2"});
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("held_end_ready", 64'(ready), 64'd1);

        t = 0;
        while (sb.size() != 0 && t < 300) begin @(negedge clk); t++; end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
